// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive paths.
// Parity, stop-bit and FSM encodings plus config normalisation.
package uart_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        ODD   = 3'd1,
        EVEN  = 3'd2,
        MARK  = 3'd3,
        SPACE = 3'd4
    } parity_e;

    typedef enum logic [1:0] {
        STOP_1   = 2'd0,
        STOP_1P5 = 2'd1,
        STOP_2   = 2'd2
    } stop_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        BRK_MARK
    } tx_state_e;

    localparam int MIN_LEN = 5;

    function automatic logic [3:0] clamp_len(
        input logic [3:0] len,
        input logic [3:0] max_len
    );
        if (len < 4'(MIN_LEN)) return 4'(MIN_LEN);
        if (len > max_len) return max_len;
        return len;
    endfunction

    function automatic logic [15:0] len_mask(input logic [3:0] len);
        return (16'd1 << len) - 16'd1;
    endfunction

    function automatic parity_e norm_parity(input logic [2:0] code);
        case (code)
            3'd1:    return ODD;
            3'd2:    return EVEN;
            3'd3:    return MARK;
            3'd4:    return SPACE;
            default: return NONE;
        endcase
    endfunction

    function automatic stop_e to_stop(input logic [1:0] code);
        if (code[1]) return STOP_2;
        if (code[0]) return STOP_1P5;
        return STOP_1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud tick counter with programmable terminal count.
// bit_end pulses on the tick that completes the period.
module uart_bit_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          clear,
    input  logic          tick,
    input  logic [CW-1:0] last,
    output logic          bit_end
);

    logic [CW-1:0] cnt;

    assign bit_end = tick & ~clear & (cnt == last);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: stream in, LSB-first serial out,
// configurable length/parity/stop and line break generation.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int MAX_BITS = 9,
    parameter int OSR      = 16
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                baud_tick,
    input  logic [3:0]          cfg_len,
    input  logic [2:0]          cfg_parity,
    input  logic [1:0]          cfg_stop,
    input  logic                cfg_break,
    input  logic                s_valid,
    input  logic [MAX_BITS-1:0] s_data,
    output logic                s_ready,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(2 * OSR);

    tx_state_e           state, state_n;
    logic [MAX_BITS-1:0] shift, shift_n;
    logic [3:0]          bcnt, bcnt_n;
    logic                par_en_q, par_q;
    stop_e               stop_q;
    logic                load, tx_n, par_bit;
    logic [CW-1:0]       last;
    logic                bit_end, clr;
    logic [3:0]          len_in;
    parity_e             par_in;
    logic [MAX_BITS-1:0] data_in;

    assign len_in  = clamp_len(cfg_len, 4'(MAX_BITS));
    assign par_in  = norm_parity(cfg_parity);
    assign data_in = s_data & MAX_BITS'(len_mask(len_in));
    assign s_ready = (state == IDLE) & ~cfg_break;
    assign busy    = (state != IDLE);
    // Counter is held at zero while waiting, so an accept tick is dropped.
    assign clr     = (state == IDLE) | (state == BREAK);

    always_comb begin
        last = CW'(OSR - 1);
        unique case (1'b1)
            (state == STOP) && (stop_q == STOP_1P5):
                last = CW'(OSR + OSR / 2 - 1);
            ((state == STOP) && (stop_q == STOP_2)) || (state == BRK_MARK):
                last = CW'(2 * OSR - 1);
            default: ;
        endcase
    end

    uart_bit_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .aresetn (aresetn),
        .clear   (clr),
        .tick    (baud_tick),
        .last    (last),
        .bit_end (bit_end)
    );

    always_comb begin
        par_bit = 1'b0;
        unique case (par_in)
            ODD:     par_bit = ~(^data_in);
            EVEN:    par_bit = ^data_in;
            MARK:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        bcnt_n  = bcnt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_break) begin
                    state_n = BREAK;
                end else if (s_valid) begin
                    load    = 1'b1;
                    state_n = START;
                    shift_n = data_in;
                    bcnt_n  = len_in;
                end
            end
            START: if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    bcnt_n  = bcnt - 4'd1;
                    if (bcnt == 4'd1) state_n = par_en_q ? PARITY : STOP;
                end
            end
            PARITY:   if (bit_end) state_n = STOP;
            STOP:     if (bit_end) state_n = IDLE;
            BREAK:    if (!cfg_break) state_n = BRK_MARK;
            BRK_MARK: if (bit_end) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START, BREAK: tx_n = 1'b0;
            DATA:         tx_n = shift_n[0];
            PARITY:       tx_n = par_q;
            default:      tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            shift    <= '0;
            bcnt     <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop_q   <= STOP_1;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            bcnt  <= bcnt_n;
            tx    <= tx_n;
            done  <= (state == STOP) & bit_end;
            if (load) begin
                par_en_q <= (par_in != NONE);
                par_q    <= par_bit;
                stop_q   <= to_stop(cfg_stop);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised bench for uart_tx_engine against a per-tick frame model.
// Directed frames, back-to-back, break, tick stall and reset cases.
module tb_uart_tx_engine;

    localparam int MAXB = 9;
    localparam int OSR  = 16;
    localparam int LIM  = 5000;

    logic            clk = 1'b0;
    logic            aresetn = 1'b1;
    logic            baud_tick = 1'b0;
    logic [3:0]      cfg_len = 4'd8;
    logic [2:0]      cfg_parity = 3'd0;
    logic [1:0]      cfg_stop = 2'd0;
    logic            cfg_break = 1'b0;
    logic            s_valid = 1'b0;
    logic [MAXB-1:0] s_data = '0;
    logic            s_ready, tx, busy, done;

    int  total = 0;
    int  bad = 0;
    bit  tick_en = 1'b1;
    int  cyc = 0;
    int  cyc_done = 0;
    int  n_done = 0;
    int  n_acc = 0;
    bit  check_gap = 1'b0;
    int  gap_n = 0;
    bit  recording = 1'b0;
    bit  prev_done = 1'b0;
    int  busy_bad = 0;
    bit  exp_q[$];
    logic rec_q[$];

    uart_tx_engine #(.MAX_BITS(MAXB), .OSR(OSR)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .baud_tick  (baud_tick),
        .cfg_len    (cfg_len),
        .cfg_parity (cfg_parity),
        .cfg_stop   (cfg_stop),
        .cfg_break  (cfg_break),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        baud_tick = tick_en && ($urandom_range(0, 3) == 0);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Frame as one tx value per baud tick, built from the line format.
    function automatic void model(input logic [MAXB-1:0] d, input int len,
                                  input int par, input int stp);
        int n, ones, sticks;
        bit pb;
        n = (len < 5) ? 5 : ((len > MAXB) ? MAXB : len);
        exp_q.delete();
        ones = 0;
        repeat (OSR) exp_q.push_back(1'b0);
        for (int b = 0; b < n; b++) begin
            ones += int'(d[b]);
            repeat (OSR) exp_q.push_back(d[b]);
        end
        if (par >= 1 && par <= 4) begin
            case (par)
                1:       pb = (ones % 2 == 0);
                2:       pb = (ones % 2 == 1);
                3:       pb = 1'b1;
                default: pb = 1'b0;
            endcase
            repeat (OSR) exp_q.push_back(pb);
        end
        sticks = (stp == 0) ? OSR : ((stp == 1) ? OSR + OSR / 2 : 2 * OSR);
        repeat (sticks) exp_q.push_back(1'b1);
    endfunction

    always @(negedge clk) begin : mon
        int m;
        if (!aresetn) begin
            recording = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_width", prev_done, 0);
                check("done_in_frame", recording, 1);
                if (recording) begin
                    m = 0;
                    for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++)
                        if (rec_q[i] !== exp_q[i]) m++;
                    check("frame_ticks", rec_q.size(), exp_q.size());
                    check("frame_bits", m, 0);
                    check("frame_busy", busy_bad, 0);
                end
                n_done++;
                cyc_done = cyc;
                recording = 1'b0;
            end else if (recording && baud_tick) begin
                rec_q.push_back(tx);
                if (busy !== 1'b1) busy_bad++;
            end
            if (s_valid && s_ready) begin
                model(s_data, int'(cfg_len), int'(cfg_parity), int'(cfg_stop));
                rec_q.delete();
                recording = 1'b1;
                busy_bad = 0;
                n_acc++;
                if (check_gap && gap_n > 0) check("b2b_gap", cyc - cyc_done, 0);
                if (check_gap) gap_n++;
            end
            prev_done = done;
        end
    end

    task automatic send(input logic [MAXB-1:0] d, input int len, input int par,
                        input int stp, input bit keep);
        int t;
        s_data = d;
        cfg_len = len[3:0];
        cfg_parity = par[2:0];
        cfg_stop = stp[1:0];
        s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < LIM) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("accept_timeout", int'(t >= LIM), 0);
        @(posedge clk);
        #1;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < LIM) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle_timeout", int'(t >= LIM), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : wdog
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t, d0, ticks, txbad, srbad, changes;
        logic tx_h;
        #1 aresetn = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", s_ready, 1);
        cfg_break = 1'b1;
        #1;
        check("rst_ready_brk", s_ready, 0);
        cfg_break = 1'b0;
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk);
        #1;

        send(9'h0A5, 8, 0, 0, 0);
        wait_idle();

        send(9'h041, 7, 2, 0, 0);
        cfg_parity = 3'd1;
        wait_idle();
        send(9'h041, 7, 1, 0, 0);
        wait_idle();

        send(9'h1FF, 9, 3, 2, 0);
        wait_idle();
        send(9'h01F, 5, 0, 1, 0);
        wait_idle();

        check_gap = 1'b1;
        gap_n = 0;
        send(9'h0C6, 8, 0, 0, 1);
        send(9'h139, 8, 2, 0, 1);
        send(9'h07E, 8, 4, 1, 0);
        wait_idle();
        check("b2b_count", gap_n, 3);
        check_gap = 1'b0;

        send(9'h03C, 8, 0, 0, 0);
        repeat (60) @(posedge clk);
        #1 tick_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tx_h = tx;
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== tx_h) changes++;
        end
        check("stall_tx", changes, 0);
        check("stall_busy", busy, 1);
        tick_en = 1'b1;
        wait_idle();

        d0 = n_done;
        send(9'h055, 8, 0, 0, 0);
        repeat (40) @(posedge clk);
        #1 cfg_break = 1'b1;
        t = 0;
        while (n_done == d0 && t < LIM) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("brk_frame_timeout", int'(t >= LIM), 0);
        txbad = 0;
        srbad = 0;
        repeat (3) @(posedge clk);
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b0) txbad++;
            if (s_ready !== 1'b0) srbad++;
        end
        check("brk_tx_low", txbad, 0);
        check("brk_ready_low", srbad, 0);
        check("brk_busy", busy, 1);
        @(posedge clk);
        #1 cfg_break = 1'b0;
        @(posedge clk);
        ticks = 0;
        txbad = 0;
        t = 0;
        while (t < LIM) begin
            @(negedge clk);
            if (s_ready) break;
            if (baud_tick) begin
                ticks++;
                if (tx !== 1'b1) txbad++;
            end
            t++;
        end
        check("brk_mark_ticks", ticks, 2 * OSR);
        check("brk_mark_tx", txbad, 0);
        check("brk_ready", s_ready, 1);
        check("brk_no_done", n_done, d0 + 1);
        @(posedge clk);
        #1;

        send(9'h0C3, 8, 0, 0, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", s_ready, 1);
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk);
        #1;
        d0 = n_done;
        send(9'h0C3, 8, 1, 0, 0);
        wait_idle();
        check("post_rst_done", n_done, d0 + 1);

        for (int i = 0; i < 10; i++) begin
            send(MAXB'($urandom), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 (i < 9) && ($urandom_range(0, 1) == 1));
        end
        wait_idle();
        check("final_idle_ready", s_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
